// File: rtl/dmem_controller.sv
// dmem_controller
//   Sequences 32-bit word loads/stores onto a byte-wide data memory, one byte
//   per cycle, little-endian. Two requesters share the single memory port
//   (m0 = CPU MEM stage, m1 = loader/debug), arbitrated round-robin.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   mN_req_i              access request, held until mN_ack_o
//   mN_we_i               1 = store word, 0 = load word
//   mN_addr_i             byte address of the word (unaligned allowed)
//   mN_wdata_i            store data
//   mN_ack_o              one-cycle completion pulse
//   mN_rdata_o            load data, held until the next load on that port
//   mem_addr_o            byte address to memory
//   mem_wdata_o           byte to write
//   mem_we_o, mem_re_o    byte write / read strobes
//   mem_rdata_i           read byte, combinational from mem_addr_o
//   busy_o                high whenever an access is in progress
//
// state | meaning
// IDLE  | arbitrate, latch the granted request
// XFER  | move one byte per cycle, cnt = 0..3
// DONE  | ack the granted port, strobes low

module dmem_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        cnt;
  logic              last_grant;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_buf;

  logic              any_req;
  logic              grant_sel;
  logic [4:0]        byte_lsb;

  assign any_req  = m0_req_i | m1_req_i;
  // On contention pick the port that did not win last time; reset value of
  // last_grant = 1 makes the first contest go to m0.
  assign grant_sel = (m0_req_i && m1_req_i) ? ~last_grant : m1_req_i;
  assign byte_lsb = {cnt, 3'b000};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      last_grant <= 1'b1;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_buf     <= '0;
      m0_rdata_o <= '0;
      m1_rdata_o <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            port_q     <= grant_sel;
            last_grant <= grant_sel;
            we_q       <= grant_sel ? m1_we_i    : m0_we_i;
            addr_q     <= grant_sel ? m1_addr_i  : m0_addr_i;
            wdata_q    <= grant_sel ? m1_wdata_i : m0_wdata_i;
            cnt        <= 2'd0;
          end
        end
        XFER: begin
          cnt <= cnt + 2'd1;
          if (!we_q) begin
            rd_buf[byte_lsb +: 8] <= mem_rdata_i;
            // Publish the assembled word on the same edge the last byte
            // arrives so rdata is already valid during the ack cycle.
            if (cnt == 2'd3) begin
              if (port_q) m1_rdata_o <= {mem_rdata_i, rd_buf[DATA_W-9:0]};
              else        m0_rdata_o <= {mem_rdata_i, rd_buf[DATA_W-9:0]};
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    mem_addr_o  = '0;
    mem_wdata_o = 8'h00;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    m0_ack_o    = 1'b0;
    m1_ack_o    = 1'b0;
    busy_o      = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) state_nxt = XFER;
      end
      XFER: begin
        mem_addr_o = addr_q + ADDR_W'(cnt);
        if (we_q) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = wdata_q[byte_lsb +: 8];
        end else begin
          mem_re_o = 1'b1;
        end
        if (cnt == 2'd3) state_nxt = DONE;
      end
      DONE: begin
        m0_ack_o  = ~port_q;
        m1_ack_o  = port_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
